// File: rtl/block_geom_pkg.sv
// Block-field geometry shared by the line reader, the block store
// and the collision logic.
package block_geom_pkg;

    localparam int NUM_ROWS   = 16;
    localparam int NUM_COLS   = 13;
    localparam int BLOCK_TOP  = 32;
    localparam int ROW_H_LOG2 = 3;
    localparam int BLOCK_LEFT = 8;
    localparam int COL_W      = 48;

    typedef logic [3:0]            row_t;
    typedef logic [3:0]            col_t;
    typedef logic [5:0]            subx_t;
    typedef logic [9:0]            coord_t;
    typedef logic [ROW_H_LOG2-1:0] ysub_t;
    typedef logic [NUM_COLS-1:0]   line_t;

    typedef enum logic {
        RUN    = 1'b0,
        RESYNC = 1'b1
    } rd_state_e;

    localparam coord_t Y_TOP =
        coord_t'(BLOCK_TOP);
    localparam coord_t Y_END =
        coord_t'(BLOCK_TOP + (NUM_ROWS << ROW_H_LOG2));
    localparam coord_t X_LEFT =
        coord_t'(BLOCK_LEFT);
    localparam row_t  ROW_LAST  = row_t'(NUM_ROWS - 1);
    localparam col_t  COL_END   = col_t'(NUM_COLS);
    localparam subx_t SUBX_LAST = subx_t'(COL_W - 1);

    // Column 0 lives in the MSB of the line word.
    function automatic col_t line_bit(col_t c);
        return col_t'(NUM_COLS - 1) - c;
    endfunction

endpackage

// File: rtl/block_line_reader_if.sv
// Video-timing inputs, store line word and per-pixel block outputs
// between the video front end and the block line reader.
interface block_line_reader_if;
    import block_geom_pkg::*;

    logic   frame_start;
    logic   line_end;
    logic   pix_valid;
    coord_t x;
    coord_t y;
    line_t  line;
    logic   next_line;
    logic   block_on;
    row_t   block_row;
    col_t   block_col;

    modport master (
        output frame_start,
        output line_end,
        output pix_valid,
        output x,
        output y,
        output line,
        input  next_line,
        input  block_on,
        input  block_row,
        input  block_col
    );

    modport slave (
        input  frame_start,
        input  line_end,
        input  pix_valid,
        input  x,
        input  y,
        input  line,
        output next_line,
        output block_on,
        output block_row,
        output block_col
    );

endinterface

// File: rtl/block_col_tracker.sv
// Horizontal position inside the block field: pixel offset within
// the current block column and the column index itself.
module block_col_tracker
    import block_geom_pkg::*;
(
    input  logic   clk,
    input  logic   nRst,
    input  logic   i_line_end,
    input  logic   i_pix_valid,
    input  coord_t i_x,
    output col_t   o_col,
    output logic   o_active,
    output logic   o_gap
);

    subx_t r_sub_x;
    col_t  r_col;
    logic  w_x_ok;
    logic  w_col_in;

    assign w_x_ok   = (i_x >= X_LEFT);
    assign w_col_in = (r_col < COL_END);

    assign o_active = i_pix_valid & w_x_ok & w_col_in;
    assign o_gap    = (r_sub_x == SUBX_LAST);
    assign o_col    = r_col;

    // col parks at COL_END once the right edge is passed.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_sub_x <= '0;
            r_col   <= '0;
        end else if (i_line_end) begin
            r_sub_x <= '0;
            r_col   <= '0;
        end else if (o_active) begin
            if (o_gap) begin
                r_sub_x <= '0;
                r_col   <= r_col + col_t'(1);
            end else begin
                r_sub_x <= r_sub_x + subx_t'(1);
            end
        end
    end

endmodule

// File: rtl/block_line_reader.sv
// Steps the rotating block store once per band, realigns it in
// vblank, and flags pixels that fall on a present block.
module block_line_reader
    import block_geom_pkg::*;
(
    input logic clk,
    input logic nRst,
    block_line_reader_if.slave bus
);

    rd_state_e r_state;
    rd_state_e w_state_nxt;
    row_t      r_row_idx;
    row_t      w_row_nxt;
    logic      r_next_line;
    logic      r_block_on;
    row_t      r_block_row;
    col_t      r_block_col;

    logic      w_in_area;
    ysub_t     w_ysub;
    logic      w_y_last;
    logic      w_band_end;
    logic      w_row_wrap;
    logic      w_step;

    col_t      w_col;
    logic      w_active;
    logic      w_gap;
    logic      w_hit;

    assign w_in_area = (bus.y >= Y_TOP) && (bus.y < Y_END);
    assign w_ysub    = ysub_t'(bus.y - Y_TOP);
    assign w_y_last  = &w_ysub;
    assign w_band_end = bus.line_end & w_in_area & w_y_last;

    assign w_row_wrap = (r_row_idx == ROW_LAST);
    assign w_row_nxt  = w_row_wrap ? '0
                                   : r_row_idx + row_t'(1);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN: begin
                if (bus.frame_start && r_row_idx != '0)
                    w_state_nxt = RESYNC;
            end
            RESYNC: begin
                if (w_row_wrap)
                    w_state_nxt = RUN;
            end
        endcase
    end

    // frame_start masks a coincident band end.
    always_comb begin
        w_step = 1'b0;
        unique case (r_state)
            RUN:    w_step = w_band_end & ~bus.frame_start;
            RESYNC: w_step = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_next_line <= 1'b0;
            r_row_idx   <= '0;
        end else begin
            r_next_line <= w_step;
            if (w_step)
                r_row_idx <= w_row_nxt;
        end
    end

    block_col_tracker u_col (
        .clk         (clk),
        .nRst        (nRst),
        .i_line_end  (bus.line_end),
        .i_pix_valid (bus.pix_valid),
        .i_x         (bus.x),
        .o_col       (w_col),
        .o_active    (w_active),
        .o_gap       (w_gap)
    );

    // Last pixel column and last scanline of a block form the gap.
    assign w_hit = w_active & w_in_area
                 & bus.line[line_bit(w_col)]
                 & ~w_gap & ~w_y_last;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_block_on  <= 1'b0;
            r_block_row <= '0;
            r_block_col <= '0;
        end else begin
            r_block_on <= w_hit;
            if (w_hit) begin
                r_block_row <= r_row_idx;
                r_block_col <= w_col;
            end
        end
    end

    assign bus.next_line = r_next_line;
    assign bus.block_on  = r_block_on;
    assign bus.block_row = r_block_row;
    assign bus.block_col = r_block_col;

endmodule
